rom_bus_arbiter: RTL and testbench

//  Shares the single 8k instruction/constant ROM between two requesters: the fetch unit (if_*)
//  and the data/constant-load path (dm_*). Drives the ROM's cs/address and follows its

---
 rtl/rom_bus_arbiter.sv | 151 +++++++++++++++
 tb/tb_rom_bus_arbiter.sv | 312 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/rom_bus_arbiter.sv
`timescale 1ns/1ps
// rom_bus_arbiter
//   Shares one ROM between the fetch unit (if_*) and the data/constant-load
//   path (dm_*). One transaction at a time walks IDLE -> ISSUE -> WAIT_LO ->
//   WAIT_HI -> ACK. The ROM answers a one-cycle cs by dropping rom_ready while
//   busy and raising it again with rom_data valid. A wait that lasts TIMEOUT
//   cycles is aborted: bus_err pulses and the owner receives all-ones data.
//
// Ports
//   clk, rst_n            clock (rising edge), asynchronous active-low reset
//   if_req/if_addr        fetch request and address (held until if_ack)
//   if_ack/if_data        one-cycle ack; last word captured for fetch
//   dm_req/dm_addr        data-path request and address (held until dm_ack)
//   dm_ack/dm_data        one-cycle ack; last word captured for data path
//   rom_cs/rom_address    ROM chip select (one cycle per transaction), address
//   rom_ready/rom_data    ROM handshake and read data
//   busy                  high whenever the FSM is not in IDLE
//   bus_err               one-cycle pulse alongside the ack of a timed-out read
module rom_bus_arbiter #(
  parameter int ADDR_W    = 16,
  parameter int DATA_W    = 16,
  parameter int TIMEOUT   = 15,
  parameter int FIXED_PRI = 0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic              if_ack,
  output logic [DATA_W-1:0] if_data,
  input  logic              dm_req,
  input  logic [ADDR_W-1:0] dm_addr,
  output logic              dm_ack,
  output logic [DATA_W-1:0] dm_data,
  output logic              rom_cs,
  output logic [ADDR_W-1:0] rom_address,
  input  logic              rom_ready,
  input  logic [DATA_W-1:0] rom_data,
  output logic              busy,
  output logic              bus_err
);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    ISSUE   = 3'd1,
    WAIT_LO = 3'd2,
    WAIT_HI = 3'd3,
    ACK     = 3'd4
  } state_t;

  localparam logic [8:0] TIMEOUT_L = 9'(TIMEOUT);

  state_t     state_reg;
  logic       owner_reg;      // 1 = data path owns the current transaction
  logic       last_dm_reg;    // 1 = data path was served last
  logic [7:0] wait_cnt_reg;

  logic       grant_dm;
  logic [8:0] cnt_inc;
  logic       timeout_hit;
  logic       got_data;
  logic       done;

  // Round-robin favours whoever was not served last; fixed priority favours fetch.
  always_comb begin
    grant_dm = dm_req;
    if (if_req && dm_req) begin
      grant_dm = (FIXED_PRI != 0) ? 1'b0 : ~last_dm_reg;
    end
  end

  // The count after this cycle's increment; reaching TIMEOUT ends the wait,
  // so the FSM spends at most TIMEOUT cycles in WAIT_LO/WAIT_HI.
  assign cnt_inc     = {1'b0, wait_cnt_reg} + 9'd1;
  assign timeout_hit = (cnt_inc >= TIMEOUT_L);
  // Valid data wins over a timeout landing in the same cycle.
  assign got_data    = (state_reg == WAIT_HI) && rom_ready;
  assign done        = got_data ||
                       (((state_reg == WAIT_LO) || (state_reg == WAIT_HI)) && timeout_hit);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg    <= IDLE;
      owner_reg    <= 1'b0;
      last_dm_reg  <= 1'b1;   // fetch wins the first tie
      wait_cnt_reg <= '0;
      rom_cs       <= 1'b0;
      rom_address  <= '0;
      if_ack       <= 1'b0;
      dm_ack       <= 1'b0;
      if_data      <= '0;
      dm_data      <= '0;
      busy         <= 1'b0;
      bus_err      <= 1'b0;
    end else begin
      rom_cs  <= 1'b0;
      if_ack  <= 1'b0;
      dm_ack  <= 1'b0;
      bus_err <= 1'b0;

      case (state_reg)
        IDLE: begin
          // A ROM still busy from an interrupted transfer must finish first.
          if ((if_req || dm_req) && rom_ready) begin
            owner_reg   <= grant_dm;
            rom_address <= grant_dm ? dm_addr : if_addr;
            rom_cs      <= 1'b1;
            busy        <= 1'b1;
            state_reg   <= ISSUE;
          end
        end
        ISSUE: begin
          wait_cnt_reg <= '0;
          state_reg    <= WAIT_LO;
        end
        WAIT_LO: begin
          wait_cnt_reg <= wait_cnt_reg + 8'd1;
          if (!rom_ready) begin
            state_reg <= WAIT_HI;
          end
        end
        WAIT_HI: begin
          wait_cnt_reg <= wait_cnt_reg + 8'd1;
        end
        ACK: begin
          last_dm_reg <= owner_reg;
          busy        <= 1'b0;
          state_reg   <= IDLE;
        end
        default: begin
          busy      <= 1'b0;
          state_reg <= IDLE;
        end
      endcase

      // Completion (data or timeout) overrides the wait-state transitions above.
      if (done) begin
        state_reg <= ACK;
        bus_err   <= ~got_data;
        if (owner_reg) begin
          dm_ack  <= 1'b1;
          dm_data <= got_data ? rom_data : '1;
        end else begin
          if_ack  <= 1'b1;
          if_data <= got_data ? rom_data : '1;
        end
      end
    end
  end

endmodule

// File: tb/tb_rom_bus_arbiter.sv
`timescale 1ns/1ps
module tb_rom_bus_arbiter;

  localparam int ADDR_W    = 16;
  localparam int DATA_W    = 16;
  localparam int TIMEOUT   = 15;
  localparam int FIXED_PRI = 0;
  localparam int MAXC      = 8000;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic [1:0]        req_v = 2'b00;          // bit0 fetch, bit1 data path
  logic [15:0]       addr_v [2];
  logic              rom_ready = 1'b1;
  logic [15:0]       rom_data = 16'h0;
  logic              if_ack, dm_ack, rom_cs, busy, bus_err;
  logic [15:0]       if_data, dm_data, rom_address;

  always #5 clk = ~clk;

  rom_bus_arbiter #(
    .ADDR_W(ADDR_W), .DATA_W(DATA_W), .TIMEOUT(TIMEOUT), .FIXED_PRI(FIXED_PRI)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .if_req(req_v[0]), .if_addr(addr_v[0]), .if_ack(if_ack), .if_data(if_data),
    .dm_req(req_v[1]), .dm_addr(addr_v[1]), .dm_ack(dm_ack), .dm_data(dm_data),
    .rom_cs(rom_cs), .rom_address(rom_address), .rom_ready(rom_ready), .rom_data(rom_data),
    .busy(busy), .bus_err(bus_err)
  );

  int n_total = 0;
  int n_pass  = 0;
  int cyc     = 0;

  // Transaction-level model: one outstanding read with a known cs cycle and ack cycle.
  bit          m_busy = 0;
  bit          m_owner = 0;       // 1 = data path
  bit          m_err = 0;
  logic [15:0] m_addr = 0, m_word = 0;
  int          m_start = 0, m_ack = 0;
  bit          last_dm = 1;
  logic [15:0] e_if_data = 0, e_dm_data = 0;

  // ROM model: ready low for cycles [lo_start, hi_at), data valid from hi_at.
  logic [15:0] mem [8192];
  int          lo_start = 0, hi_at = 0;
  logic [15:0] rom_word = 0;
  int          pend_l = 1, pend_h = 1;
  int          force_l = 0, force_h = 0;
  bit          cs_seen = 0;
  logic [15:0] addr_seen = 0;

  bit rand_en = 0, hold_reqs = 0, chk_on = 1;
  int rst_drop_cyc = -1, rst_rel_cyc = -1;

  logic [3:0]  lg_ev  [MAXC];   // {bus_err, dm_ack, if_ack, rom_cs}
  logic [15:0] lg_ifd [MAXC];
  logic [15:0] lg_dmd [MAXC];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s cycle=%0d got=%h expected=%h", name, cyc, act, exp);
  endtask

  function automatic int first_hit(input int kind, input int from, input int to);
    for (int i = from; i <= to && i < MAXC; i++) if (lg_ev[i][kind]) return i;
    return -1;
  endfunction

  function automatic int count_hits(input int kind, input int from, input int to);
    int n;
    n = 0;
    for (int i = from; i <= to && i < MAXC; i++) if (lg_ev[i][kind]) n++;
    return n;
  endfunction

  task automatic model_reset();
    m_busy    = 0;
    last_dm   = 1;
    e_if_data = 16'h0;
    e_dm_data = 16'h0;
  endtask

  // Called at the clock edge that ends cycle 'cyc'; yields expectations for cycle cyc+1.
  task automatic step();
    int sel;
    if (cs_seen) begin
      lo_start = cyc + pend_l;
      hi_at    = cyc + pend_l + pend_h;
      rom_word = mem[addr_seen[12:0]];
    end
    if (rst_n) begin
      if (m_busy) begin
        if (cyc == m_ack) begin
          m_busy  = 0;
          last_dm = m_owner;
        end
      end else if ((req_v != 2'b00) && rom_ready) begin
        if (req_v == 2'b11) m_owner = (FIXED_PRI != 0) ? 1'b0 : !last_dm;
        else                m_owner = req_v[1];
        m_addr = addr_v[m_owner];
        if (force_l > 0) begin
          pend_l = force_l;
          pend_h = force_h;
        end else begin
          pend_l = $urandom_range(1, 3);
          sel    = $urandom_range(0, 9);
          if (sel == 0)      pend_h = $urandom_range(TIMEOUT + 1, TIMEOUT + 25);
          else if (sel == 1) pend_h = TIMEOUT - pend_l - 1 + $urandom_range(0, 2);
          else               pend_h = $urandom_range(1, 6);
        end
        m_start = cyc + 1;
        if (pend_l + pend_h <= TIMEOUT) begin
          m_err  = 0;
          m_ack  = m_start + 1 + pend_l + pend_h;
          m_word = mem[m_addr[12:0]];
        end else begin
          m_err  = 1;
          m_ack  = m_start + 1 + TIMEOUT;
          m_word = 16'hFFFF;
        end
        m_busy = 1;
      end
    end
    cyc++;
    if (m_busy && cyc == m_ack) begin
      if (m_owner) e_dm_data = m_word;
      else         e_if_data = m_word;
    end
  endtask

  task automatic drive_reqs();
    bit ack_now, owned;
    for (int r = 0; r < 2; r++) begin
      ack_now = m_busy && (cyc == m_ack) && (m_owner == r[0]);
      owned   = m_busy && (m_owner == r[0]) && (cyc < m_ack);
      if (ack_now) begin
        if (hold_reqs || (rand_en && $urandom_range(0, 2) == 0)) addr_v[r] = 16'($urandom);
        else req_v[r] = 1'b0;
      end else if (rand_en) begin
        if (owned && req_v[r] && $urandom_range(0, 15) == 0) begin
          req_v[r]  = 1'b0;              // early drop; ack must still arrive
          addr_v[r] = 16'($urandom);
        end else if (!req_v[r] && !owned && $urandom_range(0, 3) == 0) begin
          req_v[r]  = 1'b1;
          addr_v[r] = 16'($urandom);
        end
      end
    end
  endtask

  task automatic cycle();
    @(posedge clk);
    step();
    #1;
    if (cyc == rst_drop_cyc) begin
      rst_n = 1'b0;
      model_reset();
    end
    if (cyc == rst_rel_cyc) rst_n = 1'b1;
    rom_ready = !(cyc >= lo_start && cyc < hi_at);
    rom_data  = (cyc >= hi_at) ? rom_word : 16'($urandom);
    drive_reqs();
    @(negedge clk);
    cs_seen   = rom_cs;
    addr_seen = rom_address;
    if (cyc < MAXC) begin
      lg_ev[cyc]  = {bus_err, dm_ack, if_ack, rom_cs};
      lg_ifd[cyc] = if_data;
      lg_dmd[cyc] = dm_data;
    end
  endtask

  task automatic cycles(input int n);
    for (int i = 0; i < n; i++) cycle();
  endtask

  // Per-cycle comparison against the model.
  always @(negedge clk) begin
    bit e_cs, e_ack;
    if (chk_on) begin
      e_cs  = m_busy && (cyc == m_start);
      e_ack = m_busy && (cyc == m_ack);
      chk("rom_cs",  32'(rom_cs),  32'(e_cs));
      chk("if_ack",  32'(if_ack),  32'(e_ack && !m_owner));
      chk("dm_ack",  32'(dm_ack),  32'(e_ack && m_owner));
      chk("busy",    32'(busy),    32'(m_busy));
      chk("bus_err", 32'(bus_err), 32'(e_ack && m_err));
      chk("if_data", 32'(if_data), 32'(e_if_data));
      chk("dm_data", 32'(dm_data), 32'(e_dm_data));
      if (!rst_n) chk("rom_address_rst", 32'(rom_address), 32'h0);
      else if (m_busy && cyc < m_ack) chk("rom_address", 32'(rom_address), 32'(m_addr));
      if (e_ack)
        $display("txn cyc=%0d owner=%s addr=%h data=%h err=%0d", cyc,
                 m_owner ? "dm" : "if", m_addr, m_word, m_err);
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog cycle=%0d got=running expected=finished", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    int t0, n;
    for (int i = 0; i < 8192; i++) mem[i] = 16'($urandom);
    mem[13'h0012] = 16'hBEEF;
    mem[13'h0001] = 16'h1234;
    mem[13'h0002] = 16'h5678;
    mem[13'h0005] = 16'h0F0F;
    mem[13'h0033] = 16'h3C3C;
    mem[13'h0077] = 16'hA5C3;
    addr_v[0] = 16'h0;
    addr_v[1] = 16'h0;

    // Reset state
    cycles(3);
    chk("rst_cs",   32'(rom_cs),      32'h0);
    chk("rst_busy", 32'(busy),        32'h0);
    chk("rst_addr", 32'(rom_address), 32'h0);
    chk("rst_ifd",  32'(if_data),     32'h0);
    rst_n = 1'b1;
    cycles(2);

    // Single fetch: cs in cycle 1, ack in cycle 4
    force_l = 1; force_h = 1;
    t0 = cyc; req_v[0] = 1'b1; addr_v[0] = 16'h0012;
    cycles(8);
    chk("t1_cs_cycle",  32'(first_hit(0, t0, t0 + 8) - t0), 32'd1);
    chk("t1_cs_count",  32'(count_hits(0, t0, t0 + 8)),     32'd1);
    chk("t1_ack_cycle", 32'(first_hit(1, t0, t0 + 8) - t0), 32'd4);
    chk("t1_if_data",   32'(lg_ifd[t0 + 4]),                32'hBEEF);
    chk("t1_no_dm_ack", 32'(count_hits(2, t0, t0 + 8)),     32'd0);

    // Simultaneous requests after reset: fetch first, data 5 cycles later
    rst_drop_cyc = cyc + 1; rst_rel_cyc = cyc + 3;
    cycles(4);
    t0 = cyc; req_v = 2'b11; addr_v[0] = 16'h0001; addr_v[1] = 16'h0002;
    cycles(14);
    chk("t2_if_ack", 32'(first_hit(1, t0, t0 + 14) - t0), 32'd4);
    chk("t2_dm_ack", 32'(first_hit(2, t0, t0 + 14) - t0), 32'd9);
    chk("t2_if_data", 32'(lg_ifd[t0 + 4]), 32'h1234);
    chk("t2_dm_data", 32'(lg_dmd[t0 + 9]), 32'h5678);

    // Fairness: both held high -> if, dm, if, dm
    t0 = cyc; hold_reqs = 1; req_v = 2'b11;
    addr_v[0] = 16'($urandom); addr_v[1] = 16'($urandom);
    cycles(20);
    hold_reqs = 0;
    cycles(15);
    chk("t3_ack0_if", 32'(lg_ev[t0 + 4][1]),  32'd1);
    chk("t3_ack1_dm", 32'(lg_ev[t0 + 9][2]),  32'd1);
    chk("t3_ack2_if", 32'(lg_ev[t0 + 14][1]), 32'd1);
    chk("t3_ack3_dm", 32'(lg_ev[t0 + 19][2]), 32'd1);

    // Early req drop during WAIT_LO
    force_l = 2; force_h = 2;
    t0 = cyc; req_v[1] = 1'b1; addr_v[1] = 16'h0033;
    cycles(2);
    req_v[1] = 1'b0; addr_v[1] = 16'h0444;
    cycles(10);
    chk("t6_ack_count", 32'(count_hits(2, t0, t0 + 12)),     32'd1);
    chk("t6_ack_cycle", 32'(first_hit(2, t0, t0 + 12) - t0), 32'd6);
    chk("t6_cs_count",  32'(count_hits(0, t0, t0 + 12)),     32'd1);
    chk("t6_dm_data",   32'(lg_dmd[t0 + 6]),                 32'h3C3C);

    // Reset during WAIT_HI; ROM still busy afterwards
    force_l = 1; force_h = 8;
    t0 = cyc; req_v[1] = 1'b1; addr_v[1] = 16'h0077;
    rst_drop_cyc = t0 + 4; rst_rel_cyc = t0 + 6;
    cycles(1);
    force_h = 1;
    cycles(19);
    chk("t5_rst_busy",  32'(busy == 1'b0 || cyc > t0 + 4), 32'd1);
    chk("t5_rst_dmd",   32'(lg_dmd[t0 + 4]),                 32'h0);
    chk("t5_cs_after",  32'(first_hit(0, t0 + 2, t0 + 19) - t0), 32'd11);
    chk("t5_ack_cycle", 32'(first_hit(2, t0, t0 + 19) - t0), 32'd14);
    chk("t5_dm_data",   32'(lg_dmd[t0 + 14]),                32'hA5C3);

    // Timeout with ROM stuck busy, then no cs until ready returns
    force_l = 1; force_h = 100;
    t0 = cyc; req_v[1] = 1'b1; addr_v[1] = 16'h0040;
    cycles(20);
    chk("t4_ack_cycle", 32'(first_hit(2, t0, t0 + 20) - t0), 32'(2 + TIMEOUT));
    chk("t4_err_cycle", 32'(first_hit(3, t0, t0 + 20) - t0), 32'(2 + TIMEOUT));
    chk("t4_dm_data",   32'(lg_dmd[t0 + 2 + TIMEOUT]),       32'hFFFF);
    force_h = 1;
    req_v[0] = 1'b1; addr_v[0] = 16'h0005;
    cycles(90);
    chk("t4_cs_wait",   32'(first_hit(0, t0 + 2, t0 + 110) - t0), 32'd103);
    chk("t4_if_ack",    32'(first_hit(1, t0 + 2, t0 + 110) - t0), 32'd106);
    chk("t4_if_data",   32'(lg_ifd[t0 + 106]),                    32'h0F0F);

    // Randomized traffic
    force_l = 0;
    rand_en = 1;
    cycles(3000);
    rand_en = 0;
    n = 0;
    while ((m_busy || req_v != 2'b00) && n < 300) begin
      cycle();
      n++;
    end
    chk("drain_idle", 32'({m_busy, req_v}), 32'h0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
